// File: rtl/uart_pwm_frame_parser_pkg.sv
// Shared constants, function codes and parser state type for the UART PWM command path.
// The UART TX response path also uses this package.
package uart_pwm_pkg;

    localparam logic [7:0] FRAME_HDR   = 8'h55;
    localparam logic [7:0] FRAME_FTR   = 8'hAA;
    localparam logic [7:0] CRC8_POLY   = 8'h07;
    localparam int         PAYLOAD_LEN = 11;

    localparam logic [7:0] FUNC_CFG = 8'h01;
    localparam logic [7:0] FUNC_EN  = 8'h02;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_CRC,
        ST_FOOTER
    } parser_state_t;

    // A byte on the wire is 10 bit times (start, 8 data, stop).
    function automatic int timeout_cycles(input int clk_freq, input int baud_rate, input int gap_bytes);
        return clk_freq / baud_rate * 10 * gap_bytes;
    endfunction

endpackage

// File: rtl/uart_pwm_frame_parser_if.sv
// Byte input and decoded command bundle between the UART receiver, the frame parser
// and the PWM/DAC register bank.
interface uart_pwm_frame_parser_if;

    logic        uart_rx_done;
    logic [7:0]  uart_rx_data;
    logic        cmd_valid;
    logic [7:0]  reg_func;
    logic [7:0]  pwm_ch;
    logic [7:0]  ctrl_sta;
    logic [7:0]  duty_num;
    logic [15:0] pulse_dessert;
    logic [7:0]  pulse_num;
    logic [31:0] pattern;
    logic        crc_err;
    logic        frame_err;
    logic        busy;

    // The master side feeds bytes in and consumes the decoded commands.
    modport master (
        output uart_rx_done, uart_rx_data,
        input  cmd_valid, reg_func, pwm_ch, ctrl_sta, duty_num,
               pulse_dessert, pulse_num, pattern, crc_err, frame_err, busy
    );

    modport slave (
        input  uart_rx_done, uart_rx_data,
        output cmd_valid, reg_func, pwm_ch, ctrl_sta, duty_num,
               pulse_dessert, pulse_num, pattern, crc_err, frame_err, busy
    );

endinterface

// File: rtl/uart_pwm_frame_parser_crc8.sv
// Combinational byte-wide CRC-8 update: poly 0x07, MSB first, no reflection.
// The caller owns the init value and the final XOR (both zero on this link).
module crc8_d8
    import uart_pwm_pkg::*;
(
    input  logic [7:0] crc_in,
    input  logic [7:0] data,
    output logic [7:0] crc_out
);

    logic [7:0] acc;

    always_comb begin
        acc = crc_in ^ data;
        for (int i = 0; i < 8; i++) begin
            if (acc[7]) begin
                acc = {acc[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                acc = {acc[6:0], 1'b0};
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/uart_pwm_frame_parser.sv
// Deframes 14-byte 0x55 ... 0xAA command frames from the UART byte stream, checks the
// CRC-8 and emits one-cycle command, CRC-error or framing-error strobes.
module uart_pwm_frame_parser
    import uart_pwm_pkg::*;
#(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int BAUD_RATE     = 115200,
    parameter int TIMEOUT_BYTES = 3
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    uart_pwm_frame_parser_if.slave  bus
);

    localparam int TIMEOUT_CYC = timeout_cycles(CLK_FREQ, BAUD_RATE, TIMEOUT_BYTES);
    localparam int CNT_W       = $clog2(TIMEOUT_CYC + 2);

    parser_state_t state;
    parser_state_t state_next;

    logic [3:0]       idx;
    logic [87:0]      shadow;
    logic [7:0]       crc_calc;
    logic [7:0]       crc_next;
    logic [7:0]       crc_rx;
    logic [CNT_W-1:0] timeout_cnt;
    logic             timeout_hit;

    logic             rx_done;
    logic [7:0]       rx_data;

    logic             start_frame;
    logic             shift_en;
    logic             idx_inc;
    logic             crc_latch;
    logic             fire_cmd;
    logic             fire_crc;
    logic             fire_frame;

    logic             cmd_valid_q;
    logic             crc_err_q;
    logic             frame_err_q;
    logic [7:0]       reg_func_q;
    logic [7:0]       pwm_ch_q;
    logic [7:0]       ctrl_sta_q;
    logic [7:0]       duty_num_q;
    logic [15:0]      pulse_dessert_q;
    logic [7:0]       pulse_num_q;
    logic [31:0]      pattern_q;

    assign rx_done = bus.uart_rx_done;
    assign rx_data = bus.uart_rx_data;

    crc8_d8 u_crc8 (
        .crc_in  (crc_calc),
        .data    (rx_data),
        .crc_out (crc_next)
    );

    // A byte arriving in the same cycle as the limit always wins over the timeout.
    assign timeout_hit = (state != ST_IDLE) && !rx_done &&
                         (timeout_cnt == CNT_W'(TIMEOUT_CYC));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        idx_inc     = 1'b0;
        crc_latch   = 1'b0;
        fire_cmd    = 1'b0;
        fire_crc    = 1'b0;
        fire_frame  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (rx_done && rx_data == FRAME_HDR) begin
                    state_next  = ST_PAYLOAD;
                    start_frame = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (rx_done) begin
                    shift_en = 1'b1;
                    if (idx == 4'(PAYLOAD_LEN - 1)) begin
                        state_next = ST_CRC;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_CRC: begin
                if (rx_done) begin
                    crc_latch  = 1'b1;
                    state_next = ST_FOOTER;
                end
            end
            ST_FOOTER: begin
                if (rx_done) begin
                    state_next = ST_IDLE;
                    if (rx_data != FRAME_FTR) begin
                        fire_frame = 1'b1;
                    end else if (crc_rx != crc_calc) begin
                        fire_crc = 1'b1;
                    end else begin
                        fire_cmd = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (timeout_hit) begin
            state_next = ST_IDLE;
            fire_frame = 1'b1;
        end
    end

    // Frame working registers: byte index, payload shadow, running and received CRC.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx      <= '0;
            shadow   <= '0;
            crc_calc <= '0;
            crc_rx   <= '0;
        end else begin
            if (start_frame) begin
                idx      <= '0;
                crc_calc <= '0;
            end else if (shift_en) begin
                shadow   <= {shadow[79:0], rx_data};
                crc_calc <= crc_next;
                if (idx_inc) begin
                    idx <= idx + 4'd1;
                end
            end
            if (crc_latch) begin
                crc_rx <= rx_data;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timeout_cnt <= '0;
        end else if (rx_done || state == ST_IDLE) begin
            timeout_cnt <= '0;
        end else if (!timeout_hit) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    // Result strobes and the decoded fields; the fields move only on a good frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cmd_valid_q     <= 1'b0;
            crc_err_q       <= 1'b0;
            frame_err_q     <= 1'b0;
            reg_func_q      <= '0;
            pwm_ch_q        <= '0;
            ctrl_sta_q      <= '0;
            duty_num_q      <= '0;
            pulse_dessert_q <= '0;
            pulse_num_q     <= '0;
            pattern_q       <= '0;
        end else begin
            cmd_valid_q <= fire_cmd;
            crc_err_q   <= fire_crc;
            frame_err_q <= fire_frame;
            if (fire_cmd) begin
                reg_func_q      <= shadow[87:80];
                pwm_ch_q        <= shadow[79:72];
                ctrl_sta_q      <= shadow[71:64];
                duty_num_q      <= shadow[63:56];
                pulse_dessert_q <= shadow[55:40];
                pulse_num_q     <= shadow[39:32];
                pattern_q       <= shadow[31:0];
            end
        end
    end

    assign bus.cmd_valid     = cmd_valid_q;
    assign bus.crc_err       = crc_err_q;
    assign bus.frame_err     = frame_err_q;
    assign bus.reg_func      = reg_func_q;
    assign bus.pwm_ch        = pwm_ch_q;
    assign bus.ctrl_sta      = ctrl_sta_q;
    assign bus.duty_num      = duty_num_q;
    assign bus.pulse_dessert = pulse_dessert_q;
    assign bus.pulse_num     = pulse_num_q;
    assign bus.pattern       = pattern_q;
    assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_pwm_frame_parser.sv
// Directed table-driven bench for uart_pwm_frame_parser with hand-computed CRCs,
// plus hand-written timeout and mid-frame reset sequences.
module tb_uart_pwm_frame_parser;
    import uart_pwm_pkg::*;

    logic sys_clk;
    logic sys_rst_n;

    uart_pwm_frame_parser_if bus ();

    uart_pwm_frame_parser #(
        .CLK_FREQ      (50_000_000),
        .BAUD_RATE     (115200),
        .TIMEOUT_BYTES (3)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    localparam int MAXB = 17;

    typedef struct {
        logic [8*MAXB-1:0] data;
        int                len;
        logic              exp_cmd;
        logic              exp_crc;
        logic              exp_frame;
        logic [7:0]        f_reg;
        logic [7:0]        f_ch;
        logic [7:0]        f_ctrl;
        logic [7:0]        f_duty;
        logic [15:0]       f_dessert;
        logic [7:0]        f_pulse;
        logic [31:0]       f_pattern;
    } vec_t;

    vec_t vecs [7];
    vec_t rst_vec;

    int total = 0;
    int bad   = 0;
    int n_cmd = 0;
    int n_crc = 0;
    int n_frm = 0;
    int n_multi = 0;

    // Strobe tally sampled away from the active edge; overlapping strobes are counted too.
    always @(negedge sys_clk) begin
        if (bus.cmd_valid === 1'b1) n_cmd++;
        if (bus.crc_err === 1'b1) n_crc++;
        if (bus.frame_err === 1'b1) n_frm++;
        if ((32'(bus.cmd_valid) + 32'(bus.crc_err) + 32'(bus.frame_err)) > 1) n_multi++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge sys_clk);
        bus.uart_rx_done = 1'b1;
        bus.uart_rx_data = b;
        @(negedge sys_clk);
        bus.uart_rx_done = 1'b0;
    endtask

    task automatic sendBytes(input logic [8*MAXB-1:0] data, input int len);
        for (int i = 0; i < len; i++) begin
            applyStimulus(data[8*MAXB-1-8*i -: 8]);
        end
    endtask

    task automatic runVector(input string tag, input vec_t v);
        int c_cmd, c_crc, c_frm;
        c_cmd = n_cmd;
        c_crc = n_crc;
        c_frm = n_frm;
        sendBytes(v.data, v.len);
        checkOutput({tag, ".cmd_valid"}, 32'(bus.cmd_valid), 32'(v.exp_cmd));
        checkOutput({tag, ".crc_err"}, 32'(bus.crc_err), 32'(v.exp_crc));
        checkOutput({tag, ".frame_err"}, 32'(bus.frame_err), 32'(v.exp_frame));
        repeat (2) @(negedge sys_clk);
        checkOutput({tag, ".cmd_count"}, 32'(n_cmd - c_cmd), 32'(v.exp_cmd));
        checkOutput({tag, ".crc_count"}, 32'(n_crc - c_crc), 32'(v.exp_crc));
        checkOutput({tag, ".frm_count"}, 32'(n_frm - c_frm), 32'(v.exp_frame));
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, ".reg_func"}, 32'(bus.reg_func), 32'(v.f_reg));
        checkOutput({tag, ".pwm_ch"}, 32'(bus.pwm_ch), 32'(v.f_ch));
        checkOutput({tag, ".ctrl_sta"}, 32'(bus.ctrl_sta), 32'(v.f_ctrl));
        checkOutput({tag, ".duty_num"}, 32'(bus.duty_num), 32'(v.f_duty));
        checkOutput({tag, ".pulse_dessert"}, 32'(bus.pulse_dessert), 32'(v.f_dessert));
        checkOutput({tag, ".pulse_num"}, 32'(bus.pulse_num), 32'(v.f_pulse));
        checkOutput({tag, ".pattern"}, bus.pattern, v.f_pattern);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".cmd_valid"}, 32'(bus.cmd_valid), 32'd0);
        checkOutput({tag, ".crc_err"}, 32'(bus.crc_err), 32'd0);
        checkOutput({tag, ".frame_err"}, 32'(bus.frame_err), 32'd0);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, ".reg_func"}, 32'(bus.reg_func), 32'd0);
        checkOutput({tag, ".pwm_ch"}, 32'(bus.pwm_ch), 32'd0);
        checkOutput({tag, ".ctrl_sta"}, 32'(bus.ctrl_sta), 32'd0);
        checkOutput({tag, ".duty_num"}, 32'(bus.duty_num), 32'd0);
        checkOutput({tag, ".pulse_dessert"}, 32'(bus.pulse_dessert), 32'd0);
        checkOutput({tag, ".pulse_num"}, 32'(bus.pulse_num), 32'd0);
        checkOutput({tag, ".pattern"}, bus.pattern, 32'd0);
    endtask

    initial begin
        int cycles;
        int c_cmd, c_crc, c_frm;

        sys_rst_n        = 1'b0;
        bus.uart_rx_done = 1'b0;
        bus.uart_rx_data = 8'h00;

        // Expected fields after each vector; failed frames repeat the previous good values.
        vecs[0] = '{{112'h55_02_01_00_00_00_00_00_00_00_00_00_56_AA, 24'h0}, 14,
                    1'b1, 1'b0, 1'b0, FUNC_EN, 8'h01, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0000_0000};
        vecs[1] = '{{112'h55_02_01_00_00_00_00_00_00_00_00_00_55_AA, 24'h0}, 14,
                    1'b0, 1'b1, 1'b0, FUNC_EN, 8'h01, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0000_0000};
        vecs[2] = '{{112'h55_01_02_00_01_00_01_00_00_00_00_01_F2_AA, 24'h0}, 14,
                    1'b1, 1'b0, 1'b0, FUNC_CFG, 8'h02, 8'h00, 8'h01, 16'h0001, 8'h00, 32'h0000_0001};
        vecs[3] = '{136'h00_AA_13_55_02_03_01_00_00_00_00_00_00_00_00_FF_AA, 17,
                    1'b1, 1'b0, 1'b0, FUNC_EN, 8'h03, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0000_0000};
        vecs[4] = '{{112'h55_01_02_00_01_00_01_00_00_00_00_01_F2_AB, 24'h0}, 14,
                    1'b0, 1'b0, 1'b1, FUNC_EN, 8'h03, 8'h01, 8'h00, 16'h0000, 8'h00, 32'h0000_0000};
        vecs[5] = '{{112'h55_01_05_01_80_12_34_07_DE_AD_BE_EF_9E_AA, 24'h0}, 14,
                    1'b1, 1'b0, 1'b0, FUNC_CFG, 8'h05, 8'h01, 8'h80, 16'h1234, 8'h07, 32'hDEAD_BEEF};
        vecs[6] = vecs[0];
        rst_vec = '{{112'h55_02_03_00_00_00_00_00_00_00_00_00_86_AA, 24'h0}, 14,
                    1'b1, 1'b0, 1'b0, FUNC_EN, 8'h03, 8'h00, 8'h00, 16'h0000, 8'h00, 32'h0000_0000};

        repeat (3) @(negedge sys_clk);
        checkAllZero("reset");
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 7; i++) begin
            runVector($sformatf("vec%0d", i), vecs[i]);
        end

        // Partial frame: a long but legal gap, then the stall that must time out.
        c_cmd = n_cmd;
        c_crc = n_crc;
        c_frm = n_frm;
        sendBytes({40'h55_01_02_00_01, 96'h0}, 5);
        repeat (13000) @(negedge sys_clk);
        checkOutput("gap.no_timeout", 32'(n_frm - c_frm), 32'd0);
        checkOutput("gap.busy", 32'(bus.busy), 32'd1);
        applyStimulus(8'h00);
        checkOutput("stall.busy", 32'(bus.busy), 32'd1);
        cycles = 0;
        while (bus.frame_err !== 1'b1 && cycles < 14000) begin
            @(negedge sys_clk);
            cycles++;
        end
        checkOutput("timeout.latency", 32'(cycles), 32'd13021);
        checkOutput("timeout.busy", 32'(bus.busy), 32'd0);
        repeat (2) @(negedge sys_clk);
        checkOutput("timeout.frm_count", 32'(n_frm - c_frm), 32'd1);
        checkOutput("timeout.cmd_count", 32'(n_cmd - c_cmd), 32'd0);
        checkOutput("timeout.crc_count", 32'(n_crc - c_crc), 32'd0);
        runVector("after_timeout", vecs[0]);

        // Reset in the middle of a frame drops it silently and clears the fields.
        c_cmd = n_cmd;
        c_crc = n_crc;
        c_frm = n_frm;
        sendBytes(rst_vec.data, 8);
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #2;
        checkAllZero("midreset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        checkOutput("midreset.cmd_count", 32'(n_cmd - c_cmd), 32'd0);
        checkOutput("midreset.crc_count", 32'(n_crc - c_crc), 32'd0);
        checkOutput("midreset.frm_count", 32'(n_frm - c_frm), 32'd0);
        runVector("after_reset", rst_vec);

        checkOutput("strobe_overlap", 32'(n_multi), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
